spi_dac: RTL and testbench

SPI_DAC -- requirements
Module: spi_dac

---
 rtl/spi_dac_pkg.sv | 25 ++
 rtl/spi_dac_sclk_gen.sv | 35 +++
 rtl/spi_dac.sv | 126 ++++++++++++
 tb/tb_spi_dac.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared definitions for the dual-channel SPI DAC driver: state encoding,
// frame geometry and the frame-building helper.
package spi_dac_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned BIT_CNT_W  = 5;
    localparam int unsigned DIV_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } state_t;

    // Serial word sent to each DAC: two pad bits, mode bits, then the code.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [MODE_W-1:0] mode,
        input logic [DATA_W-1:0] data
    );
        return {2'b00, mode, data};
    endfunction

endpackage

// File: rtl/spi_dac_sclk_gen.sv
// SCLK generator: idles high, toggles every CLK_DIV cycles while enabled and
// flags the cycle before each rise/fall with one-cycle strobes.
module sclk_gen
    import spi_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_c,
    output logic fall_c
);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal_c;

    assign terminal_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_c     = terminal_c && sclk;
    assign rise_c     = terminal_c && !sclk;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (terminal_c) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_dac.sv
// Dual-channel SPI DAC driver: shifts two 16-bit frames out in parallel under a
// shared SYNC_N, then enforces a quiet gap before the next frame.
module spi_dac
    import spi_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned QUIET_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dac1_din,
    input  logic [DATA_W-1:0] dac2_din,
    input  logic [MODE_W-1:0] mode,
    output logic              sync_n,
    output logic              sclk,
    output logic              dout1,
    output logic              dout2,
    output logic              ready,
    output logic              done
);

    state_t                state, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0]      quiet_cnt, quiet_cnt_d;
    logic [FRAME_BITS-1:0] sh1, sh1_d, sh2, sh2_d;
    logic                  sync_n_d, ready_d, done_d;
    logic                  sclk_en, sclk_rise, sclk_fall;

    assign sclk_en = (state == SHIFT);

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (sclk_en),
        .sclk   (sclk),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    // Zero-filled shifting leaves the registers clear once the frame is out,
    // so the data lines read 0 outside SHIFT without extra muxing.
    assign dout1 = sh1[FRAME_BITS-1];
    assign dout2 = sh2[FRAME_BITS-1];

    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        quiet_cnt_d = quiet_cnt;
        sh1_d       = sh1;
        sh2_d       = sh2;
        sync_n_d    = sync_n;
        ready_d     = 1'b0;
        done_d      = 1'b0;

        unique case (state)
            IDLE: begin
                ready_d  = 1'b1;
                sync_n_d = 1'b1;
                if (start) begin
                    state_d   = SHIFT;
                    sh1_d     = build_frame(mode, dac1_din);
                    sh2_d     = build_frame(mode, dac2_din);
                    bit_cnt_d = '0;
                    sync_n_d  = 1'b0;
                    ready_d   = 1'b0;
                end
            end
            SHIFT: begin
                // Count falls; the rise after the last fall closes the frame.
                if (sclk_fall) begin
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                end
                if (sclk_rise) begin
                    sh1_d = {sh1[FRAME_BITS-2:0], 1'b0};
                    sh2_d = {sh2[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt == BIT_CNT_W'(FRAME_BITS)) begin
                        state_d     = QUIET;
                        sync_n_d    = 1'b1;
                        done_d      = 1'b1;
                        bit_cnt_d   = '0;
                        quiet_cnt_d = '0;
                    end
                end
            end
            QUIET: begin
                sync_n_d = 1'b1;
                if (quiet_cnt == DIV_W'(QUIET_CYC - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    quiet_cnt_d = quiet_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                sync_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            sh1       <= '0;
            sh2       <= '0;
            sync_n    <= 1'b1;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            quiet_cnt <= quiet_cnt_d;
            sh1       <= sh1_d;
            sh2       <= sh2_d;
            sync_n    <= sync_n_d;
            ready     <= ready_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_dac.sv
// Directed self-checking bench for spi_dac (CLK_DIV=4, QUIET_CYC=8).
module tb_spi_dac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] dac1_din = '0;
    logic [11:0] dac2_din = '0;
    logic [1:0]  mode = '0;
    logic        sync_n, sclk, dout1, dout2, ready, done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Line monitor: decodes frames as a DAC would (sample on SCLK fall).
    logic [15:0] cur1 = '0, cur2 = '0, last1 = '0, last2 = '0;
    int cur_bits = 0, last_bits = 0, cur_low = 0, last_low = 0;
    int high_run = 0, last_gap = 0, frame_cnt = 0, done_cnt = 0, viol = 0;
    logic prev_sync = 1'b1, prev_sclk = 1'b1, prev_d1 = 1'b0, prev_d2 = 1'b0;

    always #5 clk = ~clk;

    spi_dac #(
        .CLK_DIV   (4),
        .QUIET_CYC (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dac1_din (dac1_din),
        .dac2_din (dac2_din),
        .mode     (mode),
        .sync_n   (sync_n),
        .sclk     (sclk),
        .dout1    (dout1),
        .dout2    (dout2),
        .ready    (ready),
        .done     (done)
    );

    always @(negedge clk) begin
        if (prev_sync === 1'b1 && sync_n === 1'b0) begin
            cur1 = '0; cur2 = '0; cur_bits = 0; cur_low = 0; last_gap = high_run;
        end
        if (sync_n === 1'b0) begin
            cur_low++;
            if (prev_sclk === 1'b1 && sclk === 1'b0) begin
                cur1 = {cur1[14:0], dout1};
                cur2 = {cur2[14:0], dout2};
                cur_bits++;
            end
            if (prev_sync === 1'b0 && (dout1 !== prev_d1 || dout2 !== prev_d2)
                && !(prev_sclk === 1'b0 && sclk === 1'b1))
                viol++;
        end
        if (prev_sync === 1'b0 && sync_n === 1'b1) begin
            last1 = cur1; last2 = cur2; last_bits = cur_bits; last_low = cur_low;
            frame_cnt++;
        end
        high_run = (sync_n === 1'b1) ? high_run + 1 : 0;
        if (done === 1'b1) done_cnt++;
        prev_sync = sync_n; prev_sclk = sclk; prev_d1 = dout1; prev_d2 = dout2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, output bit ok);
        for (int i = 0; i < 3000 && frame_cnt < target; i++) tick();
        ok = (frame_cnt >= target);
    endtask

    task automatic wait_ready(output bit ok);
        for (int i = 0; i < 500 && ready !== 1'b1; i++) tick();
        ok = (ready === 1'b1);
    endtask

    task automatic wait_bits(input int n, output bit ok);
        for (int i = 0; i < 1000 && cur_bits < n; i++) tick();
        ok = (cur_bits >= n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        total_cnt++; if (sync_n !== 1'b1) $display("FAIL reset_sync_n: got %b want 1", sync_n); else pass_cnt++;
        total_cnt++; if (sclk !== 1'b1) $display("FAIL reset_sclk: got %b want 1", sclk); else pass_cnt++;
        total_cnt++; if (dout1 !== 1'b0) $display("FAIL reset_dout1: got %b want 0", dout1); else pass_cnt++;
        total_cnt++; if (dout2 !== 1'b0) $display("FAIL reset_dout2: got %b want 0", dout2); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_frame;
        int f0, d0;
        bit ok;
        f0 = frame_cnt; d0 = done_cnt;
        dac1_din = 12'hA5A; dac2_din = 12'h5A5; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (sync_n !== 1'b0) $display("FAIL start_sync_n: got %b want 0", sync_n); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL start_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (sclk !== 1'b1) $display("FAIL start_sclk: got %b want 1", sclk); else pass_cnt++;
        total_cnt++; if (dout1 !== 1'b0 || dout2 !== 1'b0) $display("FAIL start_bit15: got %b%b want 00", dout1, dout2); else pass_cnt++;
        wait_frames(f0 + 1, ok);
        total_cnt++; if (!ok) $display("FAIL frame_timeout: got %0d frames want %0d", frame_cnt, f0 + 1); else pass_cnt++;
        wait_ready(ok);
        total_cnt++; if (!ok) $display("FAIL frame_ready_timeout: ready %b want 1", ready); else pass_cnt++;
        total_cnt++; if (last1 !== 16'h0A5A) $display("FAIL frame_ch1: got %h want 0a5a", last1); else pass_cnt++;
        total_cnt++; if (last2 !== 16'h05A5) $display("FAIL frame_ch2: got %h want 05a5", last2); else pass_cnt++;
        total_cnt++; if (last_bits !== 16) $display("FAIL frame_bits: got %0d want 16", last_bits); else pass_cnt++;
        total_cnt++; if (last_low !== 128) $display("FAIL frame_sync_low: got %0d want 128", last_low); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL frame_done: got %0d want 1", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (viol !== 0) $display("FAIL frame_dout_stable: got %0d changes off sclk rise want 0", viol); else pass_cnt++;
    endtask

    task automatic test_mode;
        int f0, d0;
        bit ok;
        f0 = frame_cnt; d0 = done_cnt;
        dac1_din = 12'hFFF; dac2_din = 12'h000; mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        wait_frames(f0 + 1, ok);
        total_cnt++; if (!ok) $display("FAIL mode_timeout: got %0d frames want %0d", frame_cnt, f0 + 1); else pass_cnt++;
        wait_ready(ok);
        total_cnt++; if (last1 !== 16'h3FFF) $display("FAIL mode_ch1: got %h want 3fff", last1); else pass_cnt++;
        total_cnt++; if (last2 !== 16'h3000) $display("FAIL mode_ch2: got %h want 3000", last2); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL mode_done: got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int f0, d0;
        bit ok;
        f0 = frame_cnt; d0 = done_cnt;
        dac1_din = 12'hA5A; dac2_din = 12'h5A5; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wait_bits(6, ok);
        total_cnt++; if (!ok) $display("FAIL ignore_bits_timeout: got %0d bits want 6", cur_bits); else pass_cnt++;
        start = 1'b1; dac1_din = 12'h123;
        total_cnt++; if (ready !== 1'b0) $display("FAIL ignore_ready: got %b want 0", ready); else pass_cnt++;
        tick();
        start = 1'b0;
        wait_frames(f0 + 1, ok);
        wait_ready(ok);
        repeat (30) tick();
        total_cnt++; if (last1 !== 16'h0A5A) $display("FAIL ignore_ch1: got %h want 0a5a", last1); else pass_cnt++;
        total_cnt++; if (last2 !== 16'h05A5) $display("FAIL ignore_ch2: got %h want 05a5", last2); else pass_cnt++;
        total_cnt++; if (frame_cnt - f0 !== 1) $display("FAIL ignore_frames: got %0d want 1", frame_cnt - f0); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL ignore_done: got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int f0, d0;
        bit ok;
        f0 = frame_cnt; d0 = done_cnt;
        dac1_din = 12'h321; dac2_din = 12'hABC; mode = 2'b01; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_frames(f0 + k, ok);
            if (k == 3) start = 1'b0;
            total_cnt++; if (!ok) $display("FAIL b2b_timeout: frame %0d not seen", k); else pass_cnt++;
            total_cnt++; if (last1 !== 16'h1321) $display("FAIL b2b_ch1: frame %0d got %h want 1321", k, last1); else pass_cnt++;
            total_cnt++; if (last2 !== 16'h1ABC) $display("FAIL b2b_ch2: frame %0d got %h want 1abc", k, last2); else pass_cnt++;
            if (k > 1) begin
                total_cnt++; if (last_gap !== 9) $display("FAIL b2b_gap: frame %0d got %0d want 9", k, last_gap); else pass_cnt++;
            end
        end
        wait_ready(ok);
        repeat (20) tick();
        total_cnt++; if (frame_cnt - f0 !== 3) $display("FAIL b2b_frames: got %0d want 3", frame_cnt - f0); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 3) $display("FAIL b2b_done: got %0d want 3", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int f0, d0;
        bit ok;
        f0 = frame_cnt; d0 = done_cnt;
        dac1_din = 12'h456; dac2_din = 12'hBCD; mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wait_bits(5, ok);
        total_cnt++; if (!ok) $display("FAIL rmid_bits_timeout: got %0d bits want 5", cur_bits); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if (sync_n !== 1'b1) $display("FAIL rmid_sync_n: got %b want 1", sync_n); else pass_cnt++;
        total_cnt++; if (sclk !== 1'b1) $display("FAIL rmid_sclk: got %b want 1", sclk); else pass_cnt++;
        total_cnt++; if (dout1 !== 1'b0 || dout2 !== 1'b0) $display("FAIL rmid_dout: got %b%b want 00", dout1, dout2); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", ready); else pass_cnt++;
        reset = 1'b0;
        repeat (10) tick();
        total_cnt++; if (done_cnt !== d0) $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (last_bits !== 5) $display("FAIL rmid_partial_bits: got %0d want 5", last_bits); else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frames(f0 + 2, ok);
        total_cnt++; if (!ok) $display("FAIL rmid_timeout: got %0d frames want %0d", frame_cnt, f0 + 2); else pass_cnt++;
        wait_ready(ok);
        total_cnt++; if (last1 !== 16'h2456) $display("FAIL rmid_ch1: got %h want 2456", last1); else pass_cnt++;
        total_cnt++; if (last2 !== 16'h2BCD) $display("FAIL rmid_ch2: got %h want 2bcd", last2); else pass_cnt++;
        total_cnt++; if (last_bits !== 16) $display("FAIL rmid_bits: got %0d want 16", last_bits); else pass_cnt++;
        total_cnt++; if (last_low !== 128) $display("FAIL rmid_sync_low: got %0d want 128", last_low); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL rmid_done: got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mode();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        total_cnt++; if (viol !== 0) $display("FAIL dout_stable_all: got %0d changes off sclk rise want 0", viol); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
